// File: rtl/neuron_lut_pkg.sv
// Shared types and default widths for the streaming neuron lookup table.
package neuron_lut_pkg;

  localparam int IN_BITS_DEF  = 4;
  localparam int OUT_BITS_DEF = 2;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/neuron_lut_mem.sv
// Lookup table storage: synchronous write, asynchronous read (maps to LUT RAM).
module neuron_lut_mem
  import neuron_lut_pkg::*;
#(
  parameter int ADDR_BITS = IN_BITS_DEF,
  parameter int DATA_BITS = OUT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; a reset port would stop it mapping to LUT RAM,
  // and contents are meaningless until a full load has completed anyway.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/neuron_lut_stream.sv
// Streaming table lookup neuron: LOAD fills the table in order, RUN serves
// valid/ready lookups with one-cycle latency. NEURON_LUT_STATS_EN adds lookup_cnt.
module neuron_lut_stream
  import neuron_lut_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_done,
  input  logic [IN_BITS-1:0]  M0,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] M1,
  output logic                out_valid,
  input  logic                out_ready
`ifdef NEURON_LUT_STATS_EN
  ,
  output logic [31:0]         lookup_cnt
`endif
);

  localparam logic [IN_BITS-1:0] LAST_ADDR = '1;

  state_e              state_q, state_d;
  logic [IN_BITS-1:0]  load_cnt_q, load_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] m1_q, m1_d;
  logic                mem_we;
  logic                accept;
  logic [OUT_BITS-1:0] rd_data;

  neuron_lut_mem #(
    .ADDR_BITS (IN_BITS),
    .DATA_BITS (OUT_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_cnt_q),
    .wdata (cfg_data),
    .raddr (M0),
    .rdata (rd_data)
  );

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // FSM: next state; cfg_start takes priority over a same-cycle cfg_valid
  always_comb begin
    // NOTE: defaulting every comb output first keeps unlisted paths from inferring latches.
    state_d = state_q;
    case (state_q)
      LOAD: if (!cfg_start && cfg_valid && load_cnt_q == LAST_ADDR) state_d = RUN;
      RUN:  if (cfg_start) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_done = (state_q == RUN);
    in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    mem_we   = (state_q == LOAD) && cfg_valid && !cfg_start;
  end

  assign accept = in_valid && in_ready;

  // Datapath: write pointer wraps to 0 naturally after the last entry
  always_comb begin
    load_cnt_d  = load_cnt_q;
    out_valid_d = out_valid_q;
    m1_d        = m1_q;
    if (cfg_start)   load_cnt_d = '0;
    else if (mem_we) load_cnt_d = load_cnt_q + 1'b1;
    if (accept) begin
      out_valid_d = 1'b1;
      m1_d        = rd_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      m1_q        <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      out_valid_q <= out_valid_d;
      m1_q        <= m1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign M1        = m1_q;

`ifdef NEURON_LUT_STATS_EN
  logic [31:0] lookup_cnt_q, lookup_cnt_d;

  // Saturating count of accepted lookups; a reload request clears it
  always_comb begin
    lookup_cnt_d = lookup_cnt_q;
    if (cfg_start)                           lookup_cnt_d = '0;
    else if (accept && lookup_cnt_q != '1)   lookup_cnt_d = lookup_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lookup_cnt_q <= '0;
    else     lookup_cnt_q <= lookup_cnt_d;
  end

  assign lookup_cnt = lookup_cnt_q;
`endif

endmodule

// File: tb/tb_neuron_lut_stream.sv
// Randomized self-checking bench for neuron_lut_stream against a queue/array
// reference model of the table and the output register.
module tb_neuron_lut_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic [1:0] cfg_data;
  logic       cfg_done;
  logic [3:0] m0;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] m1;
  logic       out_valid;
  logic       out_ready;
`ifdef NEURON_LUT_STATS_EN
  logic [31:0] lookup_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: loaded flag, write pointer, table image, pending results
  bit          mdl_run;
  int          mdl_cnt;
  logic [1:0]  tab [16];
  logic [1:0]  exp_q [$];
  longint unsigned exp_lookups;

  neuron_lut_stream dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_done  (cfg_done),
    .M0        (m0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M1        (m1),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef NEURON_LUT_STATS_EN
    ,
    .lookup_cnt(lookup_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check outputs at the negedge, advance the model by one clock, then return
  // #1 after the posedge so the caller can drive the next cycle's inputs.
  task automatic step();
    bit exp_rdy, acc, cons;
    @(negedge clk);
    exp_rdy = mdl_run && (exp_q.size() == 0 || out_ready);
    check("cfg_done", cfg_done, mdl_run);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("m1", m1, exp_q[0]);
`ifdef NEURON_LUT_STATS_EN
    check("lookup_cnt", lookup_cnt, exp_lookups[31:0]);
`endif
    acc  = in_valid && exp_rdy;
    cons = (exp_q.size() != 0) && out_ready;
    if (cons) void'(exp_q.pop_front());
    if (acc)  exp_q.push_back(tab[m0]);
    if (cfg_start)                            exp_lookups = 0;
    else if (acc && exp_lookups < 64'hFFFF_FFFF) exp_lookups++;
    if (!mdl_run) begin
      if (cfg_start) mdl_cnt = 0;
      else if (cfg_valid) begin
        tab[mdl_cnt] = cfg_data;
        if (mdl_cnt == 15) begin
          mdl_run = 1'b1;
          mdl_cnt = 0;
        end else begin
          mdl_cnt++;
        end
      end
    end else if (cfg_start) begin
      mdl_run = 1'b0;
      mdl_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mdl_run = 1'b0;
    mdl_cnt = 0;
    exp_q.delete();
    exp_lookups = 0;
    #1;
    check("rst_cfg_done", cfg_done, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_m1", m1, 2'b00);
`ifdef NEURON_LUT_STATS_EN
    check("rst_lookup_cnt", lookup_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One table write, optionally preceded by an idle cycle
  task automatic load_entry(input logic [1:0] d);
    repeat ($urandom_range(0, 1)) begin
      cfg_valid = 1'b0;
      step();
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic lookups(input int n, input bit rand_ready);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      m0        = 4'($urandom);
      out_ready = rand_ready ? 1'($urandom) : 1'b1;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 2'b00;
    m0 = 4'd0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) tab[i] = 2'b00;
    @(posedge clk);
    #1;
    do_reset();

    // Reference table: 01 at addresses 7,10,11,13,14,15, otherwise 10
    for (int a = 0; a < 16; a++)
      load_entry((a == 7 || a == 10 || a == 11 || a == 13 || a == 14 || a == 15) ? 2'b01 : 2'b10);
    check("done_after_load", cfg_done, 1'b1);

    // Stream every address back to back
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      m0 = 4'(i);
      step();
    end
    in_valid = 1'b0;
    step();

    // Backpressure for three cycles on a held result
    in_valid = 1'b1; m0 = 4'b1101; out_ready = 1'b1;
    step();
    m0 = 4'($urandom); out_ready = 1'b0;
    repeat (3) step();
    check("stall_m1", m1, 2'b01);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) step();

    lookups(150, 1'b1);

    // Reload requested while a result is pending and stalled
    in_valid = 1'b1; m0 = 4'($urandom); out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 2'b00;
    step();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    repeat (2) step();
    check("reload_done_low", cfg_done, 1'b0);
    out_ready = 1'b1;
    step();
    for (int a = 0; a < 16; a++) load_entry(2'b11);
    lookups(24, 1'b1);

    // Restart of a load in progress
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int a = 0; a < 3; a++) load_entry(2'b00);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int a = 0; a < 16; a++) load_entry(2'($urandom));
    lookups(40, 1'b1);

    // Reset part way through a load
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int a = 0; a < 5; a++) load_entry(2'($urandom));
    do_reset();
    for (int a = 0; a < 16; a++) load_entry(2'($urandom));
    lookups(40, 1'b1);

    // Exactly 20 accepted lookups, then a reload request
    do_reset();
    for (int a = 0; a < 16; a++) load_entry(2'($urandom));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      m0 = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
`ifdef NEURON_LUT_STATS_EN
    check("stats_20", lookup_cnt, 32'd20);
`endif
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
`ifdef NEURON_LUT_STATS_EN
    check("stats_clear", lookup_cnt, 32'd0);
`endif
    for (int a = 0; a < 16; a++) load_entry(2'($urandom));

    // Mixed random traffic including occasional reload requests
    for (int i = 0; i < 800; i++) begin
      cfg_start = ($urandom_range(0, 99) == 0);
      cfg_valid = 1'($urandom);
      cfg_data  = 2'($urandom);
      in_valid  = 1'($urandom);
      m0        = 4'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
